// File: rtl/md_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// ALU control and flag indices are also used by the execute-stage ALU decoder.
package md_pkg;

    localparam int LOOP_ITERS = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_A,
        S_ABS_B,
        S_LOOP,
        S_NEG_LO,
        S_NEG_HI,
        S_DONE
    } md_state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam int FLAG_EQ  = 2;
    localparam int FLAG_LTU = 1;
    localparam int FLAG_LT  = 0;

    function automatic logic is_div(md_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic signed_a(md_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic signed_b(md_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    // Ops whose architectural result is the upper/remainder half
    function automatic logic takes_hi(md_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// Multi-cycle RV32M multiply/divide controller.
// All 32-bit add/sub work is borrowed from the shared execute-stage ALU.
module md_sequencer
    import md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_src_a,
    output logic [XLEN-1:0] alu_src_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic [2:0]      alu_flags
);

    localparam int CW = $clog2(LOOP_ITERS);

    md_state_t       state, state_nx;
    md_op_t          op;
    md_op_t          req_opc;
    logic [XLEN-1:0] ra, rb, hi, lo, result;
    logic [CW-1:0]   cnt;
    logic            sa, sb, lo_zero;

    logic [XLEN-1:0] r_sh, sum, rb_abs, hi_nx;
    logic            ge, carry, op_div, neg_lo, neg_hi;
    logic            div_zero;
    logic            unused_flags;

    assign req_opc  = md_op_t'(req_op);
    assign op_div   = is_div(op);
    assign div_zero = is_div(req_opc) && (req_b == '0);
    assign r_sh     = {hi[XLEN-2:0], lo[XLEN-1]};
    assign ge       = hi[XLEN-1] | ~alu_flags[FLAG_LTU];
    assign rb_abs   = sb ? alu_result : rb;
    assign neg_lo   = op_div ? (op == OP_DIV) && (sa ^ sb) : (sa ^ sb);
    assign neg_hi   = op_div ? sa : (sa ^ sb);
    assign hi_nx    = neg_hi ? alu_result : hi;

    assign unused_flags = ^{alu_flags[FLAG_EQ], alu_flags[FLAG_LT]};

    // Carry out of hi + |a| is recovered by an unsigned wrap compare
    always_comb begin
        sum   = hi;
        carry = 1'b0;
        if (lo[0]) begin
            sum   = alu_result;
            carry = alu_result < ra;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (req_valid) state_nx = div_zero ? S_DONE : S_ABS_A;
            S_ABS_A:  state_nx = S_ABS_B;
            S_ABS_B:  state_nx = S_LOOP;
            S_LOOP:   if (cnt == CW'(LOOP_ITERS - 1)) state_nx = S_NEG_LO;
            S_NEG_LO: state_nx = S_NEG_HI;
            S_NEG_HI: state_nx = S_DONE;
            S_DONE:   if (resp_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        alu_own    = 1'b0;
        alu_src_a  = '0;
        alu_src_b  = '0;
        alu_ctrl   = ALU_ADD;
        unique case (state)
            S_IDLE: req_ready = 1'b1;
            S_ABS_A: begin
                alu_own   = 1'b1;
                alu_src_b = ra;
                alu_ctrl  = ALU_SUB;
            end
            S_ABS_B: begin
                alu_own   = 1'b1;
                alu_src_b = rb;
                alu_ctrl  = ALU_SUB;
            end
            S_LOOP: begin
                alu_own   = 1'b1;
                alu_src_a = op_div ? r_sh : hi;
                alu_src_b = op_div ? rb : ra;
                alu_ctrl  = op_div ? ALU_SUB : ALU_ADD;
            end
            S_NEG_LO: begin
                alu_own   = 1'b1;
                alu_src_b = lo;
                alu_ctrl  = ALU_SUB;
            end
            S_NEG_HI: begin
                alu_own   = 1'b1;
                alu_src_a = op_div ? '0 : ~hi;
                alu_src_b = op_div ? hi : {{(XLEN-1){1'b0}}, lo_zero};
                alu_ctrl  = op_div ? ALU_SUB : ALU_ADD;
            end
            S_DONE:  resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op      <= OP_MUL;
            ra      <= '0;
            rb      <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            lo_zero <= 1'b0;
            result  <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (req_valid) begin
                    op <= req_opc;
                    ra <= req_a;
                    rb <= req_b;
                    sa <= signed_a(req_opc) & req_a[XLEN-1];
                    sb <= signed_b(req_opc) & req_b[XLEN-1];
                    if (div_zero)
                        result <= takes_hi(req_opc) ? req_a : '1;
                end
                S_ABS_A: if (sa) ra <= alu_result;
                S_ABS_B: begin
                    rb  <= rb_abs;
                    cnt <= '0;
                    hi  <= '0;
                    lo  <= op_div ? ra : rb_abs;
                end
                S_LOOP: begin
                    cnt <= cnt + 1'b1;
                    if (op_div) begin
                        hi <= ge ? alu_result : r_sh;
                        lo <= {lo[XLEN-2:0], ge};
                    end else begin
                        hi <= {carry, sum[XLEN-1:1]};
                        lo <= {sum[0], lo[XLEN-1:1]};
                    end
                end
                S_NEG_LO: begin
                    lo_zero <= (lo == '0);
                    if (neg_lo) lo <= alu_result;
                end
                S_NEG_HI: begin
                    hi     <= hi_nx;
                    result <= takes_hi(op) ? hi_nx : lo;
                end
                default: ;
            endcase
        end
    end

    assign resp_result = result;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer with a behavioural ALU beside it.
// Directed vectors carry hand-computed results and latencies.
module tb_md_sequencer;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_result;
    logic        alu_own;
    logic [31:0] alu_src_a, alu_src_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;

    always #5 clk = ~clk;

    md_sequencer #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result),
        .alu_own    (alu_own),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_flags  (alu_flags)
    );

    // Shared ALU stand-in
    assign alu_result = (alu_ctrl == ALU_SUB) ? alu_src_a - alu_src_b
                                              : alu_src_a + alu_src_b;
    assign alu_flags = {alu_src_a == alu_src_b,
                        alu_src_a < alu_src_b,
                        $signed(alu_src_a) < $signed(alu_src_b)};

    typedef struct {
        logic [31:0] res;
        int          lat;
        bit          noalu;
        int          acc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   first_cyc = 0;
    bit   seen = 0;
    bit   alu_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (alu_own) alu_seen = 1;
            if (resp_valid && !seen) begin
                seen = 1;
                first_cyc = cyc;
            end
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_resp: got %h", resp_result);
                end else begin
                    e = q.pop_front();
                    chk({e.name, " result"}, resp_result, e.res);
                    chk({e.name, " latency"}, 32'(first_cyc - e.acc + 1),
                        32'(e.lat));
                    if (e.noalu)
                        chk({e.name, " alu_own"}, 32'(alu_seen), 32'd0);
                end
                seen = 0;
            end
        end
    end

    task automatic issue(input string nm, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
        exp_t e;
        @(negedge clk);
        chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.res   = res;
        e.lat   = lat;
        e.noalu = (lat == 1);
        e.acc   = cyc;
        e.name  = nm;
        alu_seen = 0;
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL timeout: %0d responses outstanding, required 0",
                     q.size());
            q.delete();
        end
    endtask

    task automatic run(input string nm, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat);
        issue(nm, op, a, b, res, lat);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #12;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_result", resp_result, 32'd0);
        chk("rst alu_own", 32'(alu_own), 32'd0);
        chk("rst alu_src_a", alu_src_a, 32'd0);
        chk("rst alu_src_b", alu_src_b, 32'd0);
        chk("rst alu_ctrl", 32'(alu_ctrl), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 37);
        run("mul_ff",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 37);
        run("mulh_m1x2", 3'd1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 37);
        run("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 37);
        run("mul_m1x2",  3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 37);
        run("div_m7",  3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 37);
        run("rem_m7",  3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 37);
        run("divu_7",  3'd5, 32'h7, 32'h2, 32'h3, 37);
        run("remu_7",  3'd7, 32'h7, 32'h2, 32'h1, 37);
        run("div_z",   3'd4, 32'h5, 32'h0, 32'hFFFF_FFFF, 1);
        run("rem_z",   3'd6, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 1);
        run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 37);
        run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 37);

        // Reset while the loop counter sits at 10
        issue("mul_killed", 3'd0, 32'd3, 32'd5, 32'd15, 37);
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst alu_own", 32'(alu_own), 32'd0);
        chk("midrst req_ready", 32'(req_ready), 32'd1);
        chk("midrst alu_src_a", alu_src_a, 32'd0);
        q.delete();
        seen = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run("mul_after_rst", 3'd0, 32'd6, 32'd7, 32'd42, 37);

        // Consumer stalls for five cycles in DONE
        resp_ready = 1'b0;
        issue("mulhu_stall", 3'd3, 32'h8000_0000, 32'h4, 32'h2, 37);
        n = 0;
        while (!resp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("stall reached_done", 32'(resp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall resp_valid", 32'(resp_valid), 32'd1);
            chk("stall resp_result", resp_result, 32'h2);
            chk("stall req_ready", 32'(req_ready), 32'd0);
            chk("stall alu_own", 32'(alu_own), 32'd0);
        end
        resp_ready = 1'b1;
        drain();

        run("div_pos_neg", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 37);
        run("rem_pos_neg", 3'd6, 32'd100, 32'hFFFF_FFF9, 32'd2, 37);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
